id_serial_tx: RTL and testbench



---
 rtl/thermo_link_pkg.sv | 25 ++
 rtl/id_serial_tx_if.sv | 25 ++
 rtl/id_serial_tx_bit_timer.sv | 34 +++
 rtl/id_serial_tx.sv | 146 ++++++++++++++
 tb/tb_id_serial_tx.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/thermo_link_pkg.sv
// Shared definitions for the thermostat house link: transmitter states, line levels
// and default field widths common to the transmitter and receiver FSMs.
package thermo_link_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StMark,
        StId,
        StData,
        StPar,
        StGap
    } tx_state_e;

    localparam logic LINK_IDLE_LEVEL = 1'b0;
    localparam logic LINK_MARK       = 1'b1;

    localparam int unsigned DEF_ID_WIDTH   = 4;
    localparam int unsigned DEF_DATA_WIDTH = 4;

    // Counter width able to hold 0..v-1, never narrower than one bit.
    function automatic int unsigned clog2_min1(input int unsigned v);
        return (v <= 1) ? 1 : $clog2(v);
    endfunction

endpackage

// File: rtl/id_serial_tx_if.sv
// Request/status bundle between the control logic and the serial frame transmitter.
interface id_serial_tx_if
    import thermo_link_pkg::*;
#(
    parameter int unsigned ID_WIDTH   = DEF_ID_WIDTH,
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH
);
    logic                  start;
    logic [ID_WIDTH-1:0]   id;
    logic [DATA_WIDTH-1:0] data;
    logic                  tx;
    logic                  busy;
    logic                  done;

    modport master (
        output start, id, data,
        input  tx, busy, done
    );

    modport slave (
        input  start, id, data,
        output tx, busy, done
    );

endinterface

// File: rtl/id_serial_tx_bit_timer.sv
// Bit-time down-counter; tick_o marks the last clock of the current serial bit.
module bit_timer
    import thermo_link_pkg::*;
#(
    parameter int unsigned BIT_CYCLES = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    output logic tick_o
);

    localparam int unsigned CntW = clog2_min1(BIT_CYCLES);

    logic [CntW-1:0] cnt_q, cnt_d;

    assign tick_o = (cnt_q == '0);

    always_comb begin
        cnt_d = cnt_q - CntW'(1);
        if (clr_i || tick_o) begin
            cnt_d = CntW'(BIT_CYCLES - 1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/id_serial_tx.sv
// Serial frame transmitter: marker, ID (MSB first), payload (MSB first), even parity,
// then a low idle gap. All outputs are registered.
module id_serial_tx
    import thermo_link_pkg::*;
#(
    parameter int unsigned ID_WIDTH   = DEF_ID_WIDTH,
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned BIT_CYCLES = 1,
    parameter int unsigned IDLE_GAP   = 2
) (
    input  logic           clk,
    input  logic           rst,
    id_serial_tx_if.slave  bus
);

    localparam int unsigned SrW  = ID_WIDTH + DATA_WIDTH + 1;
    localparam int unsigned IdW  = clog2_min1(ID_WIDTH);
    localparam int unsigned DatW = clog2_min1(DATA_WIDTH);
    localparam int unsigned GapW = clog2_min1(IDLE_GAP);
    localparam int unsigned FldW = (IdW > DatW) ? IdW : DatW;
    localparam int unsigned CntW = (FldW > GapW) ? FldW : GapW;

    tx_state_e       state_q, state_d;
    logic [SrW-1:0]  sr_q, sr_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            tx_q, tx_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            tick;
    logic            timer_clr;

    // Timer is held at reload outside the bit-serial states so MARK starts a full bit.
    assign timer_clr = (state_q == StIdle) || (state_q == StGap);

    bit_timer #(
        .BIT_CYCLES(BIT_CYCLES)
    ) u_bit_timer (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (timer_clr),
        .tick_o (tick)
    );

    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        cnt_d   = cnt_q;
        tx_d    = tx_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        unique case (state_q)
            StIdle: begin
                tx_d   = LINK_IDLE_LEVEL;
                busy_d = 1'b0;
                cnt_d  = '0;
                if (bus.start) begin
                    sr_d    = {bus.id, bus.data, ^{bus.id, bus.data}};
                    state_d = StMark;
                    tx_d    = LINK_MARK;
                    busy_d  = 1'b1;
                end
            end
            StMark: begin
                if (tick) begin
                    state_d = StId;
                    tx_d    = sr_q[SrW-1];
                    sr_d    = {sr_q[SrW-2:0], 1'b0};
                    cnt_d   = '0;
                end
            end
            StId: begin
                if (tick) begin
                    // On each tick the next frame bit is loaded, even across field borders.
                    tx_d = sr_q[SrW-1];
                    sr_d = {sr_q[SrW-2:0], 1'b0};
                    if (cnt_q == CntW'(ID_WIDTH - 1)) begin
                        state_d = StData;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CntW'(1);
                    end
                end
            end
            StData: begin
                if (tick) begin
                    tx_d = sr_q[SrW-1];
                    sr_d = {sr_q[SrW-2:0], 1'b0};
                    if (cnt_q == CntW'(DATA_WIDTH - 1)) begin
                        state_d = StPar;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CntW'(1);
                    end
                end
            end
            StPar: begin
                if (tick) begin
                    state_d = StGap;
                    tx_d    = LINK_IDLE_LEVEL;
                    cnt_d   = '0;
                end
            end
            StGap: begin
                tx_d = LINK_IDLE_LEVEL;
                if (cnt_q == CntW'(IDLE_GAP - 1)) begin
                    state_d = StIdle;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            default: begin
                state_d = StIdle;
                tx_d    = LINK_IDLE_LEVEL;
                busy_d  = 1'b0;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            sr_q    <= '0;
            cnt_q   <= '0;
            tx_q    <= LINK_IDLE_LEVEL;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.tx   = tx_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;

endmodule

// File: tb/tb_id_serial_tx.sv
// Scoreboard bench for id_serial_tx: one-cycle-bit and three-cycle-bit instances.
module tb_id_serial_tx;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    id_serial_tx_if #(.ID_WIDTH(4), .DATA_WIDTH(4)) if1 ();
    id_serial_tx_if #(.ID_WIDTH(4), .DATA_WIDTH(4)) if3 ();

    id_serial_tx #(
        .ID_WIDTH   (4),
        .DATA_WIDTH (4),
        .BIT_CYCLES (1),
        .IDLE_GAP   (2)
    ) u_dut1 (
        .clk (clk),
        .rst (rst),
        .bus (if1)
    );

    id_serial_tx #(
        .ID_WIDTH   (4),
        .DATA_WIDTH (4),
        .BIT_CYCLES (3),
        .IDLE_GAP   (2)
    ) u_dut3 (
        .clk (clk),
        .rst (rst),
        .bus (if3)
    );

    typedef struct packed {
        logic tx;
        logic busy;
        logic done;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   busy_rises = 0;

    // Frame bits, marker first: {1, id, data, even parity}.
    function automatic logic [9:0] frame_bits(input logic [3:0] id, input logic [3:0] data);
        logic [7:0] payload;
        int         ones;
        payload = {id, data};
        ones = 0;
        for (int i = 0; i < 8; i++) ones += payload[i];
        return {1'b1, payload, logic'(ones % 2)};
    endfunction

    task automatic push_frame(input int bc, input logic [9:0] bits);
        for (int i = 9; i >= 0; i--) begin
            for (int k = 0; k < bc; k++) q.push_back('{tx: bits[i], busy: 1'b1, done: 1'b0});
        end
        for (int g = 0; g < 2; g++) q.push_back('{tx: 1'b0, busy: 1'b1, done: 1'b0});
        q.push_back('{tx: 1'b0, busy: 1'b0, done: 1'b1});
    endtask

    task automatic push_idle(input int n);
        for (int i = 0; i < n; i++) q.push_back('{tx: 1'b0, busy: 1'b0, done: 1'b0});
    endtask

    task automatic accept(input bit sel, input logic [3:0] id, input logic [3:0] data,
                          input bit hold);
        @(posedge clk);
        #1;
        if (sel) begin
            if3.start = 1'b1; if3.id = id; if3.data = data;
        end else begin
            if1.start = 1'b1; if1.id = id; if1.data = data;
        end
        @(posedge clk);
        #1;
        if (!hold) begin
            // Mid-frame input changes must not disturb the frame in flight.
            if (sel) begin
                if3.start = 1'b0; if3.id = 4'($urandom()); if3.data = 4'($urandom());
            end else begin
                if1.start = 1'b0; if1.id = 4'($urandom()); if1.data = 4'($urandom());
            end
        end
    endtask

    task automatic check_cycles(input bit sel, input int n, input string name);
        exp_t e;
        exp_t obs;
        logic prev_busy;
        prev_busy = 1'b0;
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            obs = sel ? {if3.tx, if3.busy, if3.done} : {if1.tx, if1.busy, if1.done};
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL %s cycle %0d: scoreboard empty, got tx/busy/done=%b", name, c, obs);
            end else begin
                e = q.pop_front();
                if (obs !== e) begin
                    errors++;
                    $display("FAIL %s cycle %0d: got tx/busy/done=%b required %b",
                             name, c, obs, e);
                end
            end
            if (obs.busy === 1'b1 && !prev_busy) busy_rises++;
            prev_busy = obs.busy;
        end
    endtask

    task automatic test_reset();
        exp_t e;
        exp_t o1;
        exp_t o3;
        push_idle(5);
        @(posedge clk);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            e  = q.pop_front();
            o1 = {if1.tx, if1.busy, if1.done};
            o3 = {if3.tx, if3.busy, if3.done};
            checks += 2;
            if (o1 !== e) begin
                errors++;
                $display("FAIL reset_dut1 cycle %0d: got %b required %b", c, o1, e);
            end
            if (o3 !== e) begin
                errors++;
                $display("FAIL reset_dut3 cycle %0d: got %b required %b", c, o3, e);
            end
            if (c == 1) rst = 1'b0;
        end
    endtask

    task automatic test_basic();
        push_frame(1, 10'b1001010110);
        accept(1'b0, 4'b0010, 4'b1011, 1'b0);
        check_cycles(1'b0, 13, "basic");
    endtask

    task automatic test_parity();
        push_frame(1, 10'b1000100001);
        accept(1'b0, 4'b0001, 4'b0000, 1'b0);
        check_cycles(1'b0, 13, "odd_parity");
    endtask

    task automatic test_stretch();
        push_frame(3, frame_bits(4'b0001, 4'b0000));
        accept(1'b1, 4'b0001, 4'b0000, 1'b0);
        check_cycles(1'b1, 33, "stretch");
    endtask

    task automatic test_back_to_back();
        busy_rises = 0;
        push_frame(1, frame_bits(4'hC, 4'h5));
        push_frame(1, frame_bits(4'hC, 4'h5));
        accept(1'b0, 4'hC, 4'h5, 1'b1);
        check_cycles(1'b0, 26, "back_to_back");
        if1.start = 1'b0;
        checks++;
        if (busy_rises != 2) begin
            errors++;
            $display("FAIL frame_count: got %0d frames required 2", busy_rises);
        end
        push_idle(3);
        check_cycles(1'b0, 3, "no_third_frame");
    endtask

    task automatic test_reset_mid();
        q.push_back('{tx: 1'b1, busy: 1'b1, done: 1'b0});
        q.push_back('{tx: 1'b1, busy: 1'b1, done: 1'b0});
        q.push_back('{tx: 1'b0, busy: 1'b1, done: 1'b0});
        accept(1'b0, 4'b1010, 4'b0110, 1'b0);
        check_cycles(1'b0, 3, "pre_reset");
        rst = 1'b1;
        if1.start = 1'b1; if1.id = 4'b0111; if1.data = 4'b1001;
        push_idle(1);
        check_cycles(1'b0, 1, "mid_reset");
        rst = 1'b0;
        push_frame(1, frame_bits(4'b0111, 4'b1001));
        @(posedge clk);
        #1;
        if1.start = 1'b0;
        check_cycles(1'b0, 13, "post_reset");
    endtask

    initial begin
        if1.start = 1'b0; if1.id = '0; if1.data = '0;
        if3.start = 1'b0; if3.id = '0; if3.data = '0;
        test_reset();
        test_basic();
        test_parity();
        test_stretch();
        test_back_to_back();
        test_reset_mid();
        if (q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_leftover: got %0d entries required 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
